// File: rtl/answer_bcd_converter.sv
// Signed answer to sign + packed BCD magnitude, one double-dabble shift per clock.
// Overflowed answers skip the conversion and report err with a zero magnitude.
module answer_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      answer,
    input  logic                  ovw,
    input  logic                  load,
    output logic                  busy,
    output logic                  valid,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_n;

    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    mag;
    logic [WIDTH-1:0]    mag_in;
    logic [WIDTH-1:0]    mag_sh;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] acc_sh;
    logic                sign_r;

    // The most negative value negates to itself; read unsigned it is the right magnitude.
    assign mag_in = answer[WIDTH-1] ? (~answer + 1'b1) : answer;

    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    assign acc_sh = {adj[4*DIGITS-2:0], mag[WIDTH-1]};
    assign mag_sh = {mag[WIDTH-2:0], 1'b0};

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        valid   = 1'b0;
        unique case (state)
            IDLE: begin
                if (load)
                    state_n = ovw ? DONE : SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == LAST)
                    state_n = DONE;
            end
            DONE: begin
                valid   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            mag    <= '0;
            acc    <= '0;
            sign_r <= 1'b0;
            sign   <= 1'b0;
            bcd    <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        if (ovw) begin
                            err  <= 1'b1;
                            sign <= 1'b0;
                            bcd  <= '0;
                        end else begin
                            mag    <= mag_in;
                            sign_r <= answer[WIDTH-1];
                            acc    <= '0;
                            count  <= '0;
                        end
                    end
                end
                SHIFT: begin
                    acc   <= acc_sh;
                    mag   <= mag_sh;
                    count <= count + 1'b1;
                    // Outputs change only once the final shift lands.
                    if (count == LAST) begin
                        bcd  <= acc_sh;
                        sign <= sign_r;
                        err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_answer_bcd_converter.sv
// Bench for answer_bcd_converter: directed corner cases plus random answers
// checked against a decimal-arithmetic reference model.
module tb_answer_bcd_converter;

    logic        clock;
    logic        reset;
    logic [15:0] answer;
    logic        ovw;
    logic        load;
    logic        busy;
    logic        valid;
    logic        sign;
    logic [19:0] bcd;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic        m_sign = 1'b0;
    logic        m_err  = 1'b0;
    logic [19:0] m_bcd  = '0;

    answer_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clock  (clock),
        .reset  (reset),
        .answer (answer),
        .ovw    (ovw),
        .load   (load),
        .busy   (busy),
        .valid  (valid),
        .sign   (sign),
        .bcd    (bcd),
        .err    (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        int m;
        logic [19:0] r;
        m = (v < 0) ? -v : v;
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called one step after an edge with the DUT idle.
    task automatic run_conv(input logic [15:0] a, input logic ov,
                            input int inject_at);
        int          lat;
        logic [19:0] eb;
        logic        es;
        logic        ee;
        if (ov) begin
            es = 1'b0;
            eb = '0;
            ee = 1'b1;
        end else begin
            es = a[15];
            eb = to_bcd(int'($signed(a)));
            ee = 1'b0;
        end
        answer = a;
        ovw    = ov;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        answer = 16'($urandom);
        ovw    = 1'($urandom);
        lat    = 0;
        check("busy_start", {31'd0, busy}, {31'd0, !ov});
        while (!valid && lat < 40) begin
            if (lat == inject_at) begin
                load   = 1'b1;
                answer = 16'd17;
                ovw    = 1'b0;
            end else begin
                load = 1'b0;
            end
            if (lat == 4)
                check("hold_out", {10'd0, sign, err, bcd},
                      {10'd0, m_sign, m_err, m_bcd});
            tick();
            lat++;
        end
        load = 1'b0;
        if (ov)
            check("ovw_lat", {31'd0, lat <= 1}, 32'd1);
        else
            check("latency", lat, 32'd16);
        check("sign", {31'd0, sign}, {31'd0, es});
        check("bcd", {12'd0, bcd}, {12'd0, eb});
        check("err", {31'd0, err}, {31'd0, ee});
        check("busy_done", {31'd0, busy}, 32'd0);
        m_sign = es;
        m_bcd  = eb;
        m_err  = ee;
        tick();
        check("valid_pulse", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        int vcount;
        reset  = 1'b0;
        load   = 1'b1;
        answer = 16'd5;
        ovw    = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_out", {10'd0, sign, err, bcd}, 32'd0);
        reset = 1'b1;
        load  = 1'b0;
        tick();

        run_conv(16'd170, 1'b0, -1);
        run_conv(16'hFFF1, 1'b0, -1);
        run_conv(16'd14, 1'b0, -1);
        run_conv(16'h7FFF, 1'b0, -1);
        run_conv(16'h8000, 1'b0, -1);
        run_conv(16'd0, 1'b0, -1);
        run_conv(16'd13, 1'b1, -1);
        run_conv(16'd170, 1'b0, 5);

        // Abort a conversion of -20 after eight shifts.
        answer = -16'sd20;
        ovw    = 1'b0;
        load   = 1'b1;
        tick();
        load = 1'b0;
        repeat (8) tick();
        reset = 1'b0;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_out", {10'd0, sign, err, bcd}, 32'd0);
        reset  = 1'b1;
        m_sign = 1'b0;
        m_err  = 1'b0;
        m_bcd  = '0;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid)
                vcount++;
            tick();
        end
        check("abort_novalid", vcount, 32'd0);
        run_conv(16'd30, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic        ov;
            int          inj;
            a   = 16'($urandom);
            ov  = ($urandom_range(0, 7) == 0);
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_conv(a, ov, inj);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
